// File: rtl/dpram_pkg.sv
// Shared types and constants for the simple dual-port RAM.
// Covers the clear-engine state encoding and the read-during-write policy codes.
package dpram_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

endpackage

// File: rtl/dpram_clear_ctrl.sv
// Clear engine: sweeps CLEAR_VALUE through the whole array and
// arbitrates the single write port between the sweep and the user.
module dpram_clear_ctrl
    import dpram_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 10,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
    parameter bit                    INIT_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    user_we,
    input  logic [DATA_WIDTH/8-1:0] user_be,
    input  logic [ADDR_WIDTH-1:0]   user_addr,
    input  logic [DATA_WIDTH-1:0]   user_data,
    output logic                    busy,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam clr_state_t RST_STATE = INIT_ON_RESET ? ST_CLEAR : ST_IDLE;

    clr_state_t            state;
    clr_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter wraps to zero on the last sweep write, ready for the next clear.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (clear) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR) state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state == ST_CLEAR);

    always_comb begin
        mem_be   = '0;
        mem_addr = user_addr;
        mem_data = user_data;
        if (busy) begin
            mem_be   = '1;
            mem_addr = cnt;
            mem_data = CLEAR_VALUE;
        end else if (user_we) begin
            mem_be   = user_be;
        end
    end

endmodule

// File: rtl/sdp_ram_ext.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read pipeline,
// selectable read-during-write policy and a sequential clear engine.
module sdp_ram_ext
    import dpram_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 10,
    parameter int                    READ_LATENCY  = 1,
    parameter int                    RDW_MODE      = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
    parameter bit                    INIT_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [DATA_WIDTH/8-1:0] byte_en_i,
    input  logic                    write_en_i,
    input  logic [ADDR_WIDTH-1:0]   write_addr_i,
    input  logic                    read_en_i,
    input  logic [ADDR_WIDTH-1:0]   read_addr_i,
    input  logic                    clear_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    read_valid_o,
    output logic                    busy_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sdp_ram_ext: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_lat
        $error("sdp_ram_ext: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy;
    logic [BYTES-1:0]      mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    dpram_clear_ctrl #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLEAR_VALUE   (CLEAR_VALUE),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_i),
        .user_we   (write_en_i),
        .user_be   (byte_en_i),
        .user_addr (write_addr_i),
        .user_data (data_i),
        .busy      (busy),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    assign busy_o = busy;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < BYTES; k++) begin
            if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_data[8*k +: 8];
        end
    end

    logic read_fire;
    logic collide;

    assign read_fire = read_en_i && !busy;
    assign collide   = read_fire && write_en_i
                     && (read_addr_i == write_addr_i)
                     && (RDW_MODE == RDW_WRITE_FIRST);

    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [BYTES-1:0]      byp_be_q;
    logic                  v1_q;
    logic [DATA_WIDTH-1:0] rd_word;

    // The array read is read-first; write-first is a bypass mux after the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
            v1_q       <= 1'b0;
        end else begin
            v1_q <= read_fire;
            if (read_fire) begin
                rd_q       <= mem[read_addr_i];
                byp_data_q <= data_i;
                byp_be_q   <= collide ? byte_en_i : '0;
            end
        end
    end

    always_comb begin
        rd_word = rd_q;
        for (int k = 0; k < BYTES; k++) begin
            if (byp_be_q[k]) rd_word[8*k +: 8] = byp_data_q[8*k +: 8];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] d2_q;
        logic                  v2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d2_q <= '0;
                v2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) d2_q <= rd_word;
            end
        end

        assign data_o       = d2_q;
        assign read_valid_o = v2_q;
    end else begin : g_lat1
        assign data_o       = rd_word;
        assign read_valid_o = v1_q;
    end

endmodule

// File: tb/tb_sdp_ram_ext.sv
// Self-checking bench for sdp_ram_ext: three shared-stimulus configurations
// against an array model, plus a separate instance for the reset-abort case.
module tb_sdp_ram_ext;

    logic        clk;
    logic        rst_n;
    logic        rst3;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
    logic        we3;
    logic [3:0]  wa;
    logic        re;
    logic        re3;
    logic [3:0]  ra;
    logic        clr;
    logic        clr3;

    logic [31:0] dout [4];
    logic        vld  [4];
    logic        bsy  [4];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sdp_ram_ext #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
                  .RDW_MODE(0), .CLEAR_VALUE(32'h0), .INIT_ON_RESET(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .data_i(wd), .byte_en_i(be),
        .write_en_i(we), .write_addr_i(wa), .read_en_i(re),
        .read_addr_i(ra), .clear_i(clr), .data_o(dout[0]),
        .read_valid_o(vld[0]), .busy_o(bsy[0]));

    sdp_ram_ext #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
                  .RDW_MODE(1), .CLEAR_VALUE(32'h0), .INIT_ON_RESET(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .data_i(wd), .byte_en_i(be),
        .write_en_i(we), .write_addr_i(wa), .read_en_i(re),
        .read_addr_i(ra), .clear_i(clr), .data_o(dout[1]),
        .read_valid_o(vld[1]), .busy_o(bsy[1]));

    sdp_ram_ext #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
                  .RDW_MODE(0), .CLEAR_VALUE(32'h0), .INIT_ON_RESET(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .data_i(wd), .byte_en_i(be),
        .write_en_i(we), .write_addr_i(wa), .read_en_i(re),
        .read_addr_i(ra), .clear_i(clr), .data_o(dout[2]),
        .read_valid_o(vld[2]), .busy_o(bsy[2]));

    sdp_ram_ext #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
                  .RDW_MODE(0), .CLEAR_VALUE(32'h0), .INIT_ON_RESET(1'b0)) u3 (
        .clk(clk), .rst_n(rst3), .data_i(wd), .byte_en_i(be),
        .write_en_i(we3), .write_addr_i(wa), .read_en_i(re3),
        .read_addr_i(ra), .clear_i(clr3), .data_o(dout[3]),
        .read_valid_o(vld[3]), .busy_o(bsy[3]));

    // Reference model: word array, sweep countdown, per-cycle expected outputs.
    logic [31:0] ref_mem [16];
    int          sweep_left;
    int          cyc;
    bit          sv [3][4096];
    logic [31:0] sd [3][4096];
    logic [31:0] last_d [3];
    int          lat [3] = '{1, 1, 2};
    int          rdw [3] = '{0, 1, 0};

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic        chk;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(logic w, logic [3:0] b, logic [3:0] a,
                                logic [31:0] d, logic r, logic [3:0] q,
                                logic c, logic [31:0] x0, logic [31:0] x1);
        vec_t v;
        v.we = w; v.be = b; v.wa = a; v.wd = d;
        v.re = r; v.ra = q; v.chk = c; v.e0 = x0; v.e1 = x1;
        return v;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw,
                                          logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [3:0] b, input logic [3:0] a,
                        input logic [31:0] d, input logic r, input logic [3:0] q,
                        input logic c);
        logic [31:0] old;
        we = w; be = b; wa = a; wd = d; re = r; ra = q; clr = c;
        @(posedge clk);
        cyc++;
        if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            if (r) begin
                old = ref_mem[q];
                for (int i = 0; i < 3; i++) begin
                    sv[i][cyc+lat[i]-1] = 1'b1;
                    sd[i][cyc+lat[i]-1] = (w && a == q && rdw[i] == 1)
                                        ? merge(old, d, b) : old;
                end
            end
            if (w) ref_mem[a] = merge(ref_mem[a], d, b);
            if (c) begin
                sweep_left = 16;
                for (int k = 0; k < 16; k++) ref_mem[k] = 32'h0;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d c%0d", i, cyc), 32'(bsy[i]),
                32'(sweep_left > 0));
            chk($sformatf("valid%0d c%0d", i, cyc), 32'(vld[i]),
                32'(sv[i][cyc]));
            if (sv[i][cyc]) last_d[i] = sd[i][cyc];
            chk($sformatf("data%0d c%0d", i, cyc), dout[i], last_d[i]);
        end
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rst3 = 1'b0;
        wd = '0; be = '0; we = 1'b0; we3 = 1'b0; wa = '0;
        re = 1'b0; re3 = 1'b0; ra = '0; clr = 1'b0; clr3 = 1'b0;
        cyc = 0; sweep_left = 0;
        for (int i = 0; i < 3; i++) last_d[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst busy%0d", i), 32'(bsy[i]), 32'd1);
            chk($sformatf("rst valid%0d", i), 32'(vld[i]), 32'd0);
            chk($sformatf("rst data%0d", i), dout[i], 32'h0);
        end
        chk("rst busy3", 32'(bsy[3]), 32'd0);
        chk("rst data3", dout[3], 32'h0);

        // Init sweep after reset release: 16 busy cycles, array cleared.
        rst_n = 1'b1;
        sweep_left = 16;
        for (int k = 0; k < 16; k++) ref_mem[k] = 32'h0;
        repeat (16) idle();
        for (int a = 0; a < 16; a++)
            step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0);

        tbl.push_back(mk(1, 4'hF, 3, 32'hA5A5_A5A5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 3, 32'h0000_3C00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0, 1, 3, 1, 32'hA5A5_3CA5, 32'hA5A5_3CA5));
        tbl.push_back(mk(1, 4'hF, 7, 32'h2222_2222, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 7, 32'h1111_1111, 1, 7, 1, 32'h2222_2222, 32'h1111_1111));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0, 1, 7, 1, 32'h1111_1111, 32'h1111_1111));
        tbl.push_back(mk(1, 4'h0, 7, 32'hFFFF_FFFF, 1, 7, 1, 32'h1111_1111, 32'h1111_1111));
        tbl.push_back(mk(1, 4'h9, 7, 32'hAABB_CCDD, 1, 7, 1, 32'h1111_1111, 32'hAA11_11DD));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0, 1, 7, 1, 32'hAA11_11DD, 32'hAA11_11DD));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0, 0, 7, 1, 32'hAA11_11DD, 32'hAA11_11DD));
        tbl.push_back(mk(1, 4'hF, 0, 32'h0000_0010, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 1, 32'h0000_0020, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 2, 32'h0000_0030, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0, 1, 0, 1, 32'h10, 32'h10));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0, 1, 1, 1, 32'h20, 32'h20));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0, 1, 2, 1, 32'h30, 32'h30));
        tbl.push_back(mk(0, 4'h0, 0, 32'h0, 0, 0, 1, 32'h30, 32'h30));

        foreach (tbl[j]) begin
            step(tbl[j].we, tbl[j].be, tbl[j].wa, tbl[j].wd,
                 tbl[j].re, tbl[j].ra, 1'b0);
            if (tbl[j].chk) begin
                chk($sformatf("tbl%0d v0", j), 32'(vld[0]), 32'(tbl[j].re));
                chk($sformatf("tbl%0d d0", j), dout[0], tbl[j].e0);
                chk($sformatf("tbl%0d d1", j), dout[1], tbl[j].e1);
            end
        end
        repeat (3) idle();

        // Clear pulse, user traffic and a second clear during the sweep.
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1);
        for (int s = 0; s < 16; s++)
            step(1'b1, 4'hF, 4'(s), $urandom, 1'b1, 4'(15 - s), s == 4);
        for (int a = 0; a < 16; a++)
            step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] a;
            logic [3:0] q;
            a = 4'($urandom_range(0, 15));
            q = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            step(1'($urandom), 4'($urandom), a, $urandom, 1'($urandom), q,
                 $urandom_range(0, 59) == 0);
        end
        repeat (20) idle();

        // Reset mid-sweep on the INIT_ON_RESET=0 instance.
        we = 1'b0; re = 1'b0; clr = 1'b0;
        rst3 = 1'b1;
        @(posedge clk); #1;
        chk("u3 idle after release", 32'(bsy[3]), 32'd0);
        we3 = 1'b1; be = 4'hF; wa = 4'd12; wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wa = 4'd3; wd = 32'h1234_5678;
        @(posedge clk); #1;
        we3 = 1'b0; re3 = 1'b1; ra = 4'd12;
        @(posedge clk); #1;
        chk("u3 valid rd12", 32'(vld[3]), 32'd1);
        chk("u3 data rd12", dout[3], 32'hDEAD_BEEF);
        re3 = 1'b0; clr3 = 1'b1;
        @(posedge clk); #1;
        clr3 = 1'b0;
        chk("u3 busy on clear", 32'(bsy[3]), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("u3 busy at sweep 8", 32'(bsy[3]), 32'd1);
        rst3 = 1'b0;
        #1;
        chk("u3 busy in reset", 32'(bsy[3]), 32'd0);
        chk("u3 data in reset", dout[3], 32'h0);
        chk("u3 valid in reset", 32'(vld[3]), 32'd0);
        #1 rst3 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            chk($sformatf("u3 no sweep %0d", n), 32'(bsy[3]), 32'd0);
        end
        re3 = 1'b1; ra = 4'd12;
        @(posedge clk); #1;
        chk("u3 addr12 kept", dout[3], 32'hDEAD_BEEF);
        ra = 4'd3;
        @(posedge clk); #1;
        chk("u3 addr3 swept valid", 32'(vld[3]), 32'd1);
        chk("u3 addr3 swept", dout[3], 32'h0);
        re3 = 1'b0;
        @(posedge clk); #1;
        chk("u3 hold", dout[3], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
